// File: rtl/lab5_event_encoder.sv
// lab5_event_encoder: 8-line rising-edge event collector with a valid/ready
// code presenter. Pending events are kept in one bit per line, and the
// presenter hands them out one at a time.
// Optional build macro LAB5_EVENT_ENCODER_ROUND_ROBIN_EN replaces the fixed
// highest-index-first priority with a round-robin search that starts below
// the last acknowledged code.
module lab5_event_encoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       z0,
   input  logic       z1,
   input  logic       z2,
   input  logic       z3,
   input  logic       z4,
   input  logic       z5,
   input  logic       z6,
   input  logic       z7,
   input  logic       ready,
   output logic       a0,
   output logic       a1,
   output logic       a2,
   output logic       valid,
   output logic [3:0] pend_cnt,
   output logic       ovf
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t     state, state_nxt;
   logic [7:0] z_vec, z_prev, edge_det;
   logic [7:0] pend, pend_nxt, clr;
   logic [2:0] code, code_nxt;
   logic       ack, ovf_set;

`ifdef LAB5_EVENT_ENCODER_ROUND_ROBIN_EN
   logic [2:0] ptr, ptr_nxt;

   // Round-robin pick: search base-1 downwards with wrap, base itself last.
   function automatic logic [2:0] pick(input logic [7:0] vec, input logic [2:0] base);
      logic [2:0] sel;
      logic [2:0] idx;
      sel = 3'd0;
      // walk from farthest (base) to nearest (base-1); the nearest hit wins
      for (int i = 8; i >= 1; i--) begin
         idx = base - 3'(i);
         if (vec[idx]) sel = idx;
      end
      return sel;
   endfunction
`else
   // Fixed priority pick: the highest set index wins.
   function automatic logic [2:0] pick(input logic [7:0] vec, input logic [2:0] base);
      logic [2:0] sel;
      logic [2:0] unused_base;
      unused_base = base;
      sel = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (vec[i]) sel = 3'(i);
      end
      return sel ^ (unused_base & 3'd0);
   endfunction
`endif

   assign z_vec    = {z7, z6, z5, z4, z3, z2, z1, z0};
   assign edge_det = z_vec & ~z_prev;
   assign ack      = (state == PRESENT) && ready;
   assign valid    = (state == PRESENT);
   assign {a2, a1, a0} = code;

   // Pending update: drop the acknowledged bit, then add this cycle's edges;
   // a fresh edge on the bit being acknowledged therefore survives.
   always_comb begin
      clr = 8'h00;
      if (ack) clr[code] = 1'b1;
      pend_nxt = (pend & ~clr) | edge_det;
      ovf_set  = |(edge_det & pend & ~clr);
   end

   // Presenter next state: select only on entry to PRESENT or on acknowledge.
   always_comb begin
      state_nxt = state;
      code_nxt  = code;
`ifdef LAB5_EVENT_ENCODER_ROUND_ROBIN_EN
      ptr_nxt   = ptr;
`endif
      case (state)
         IDLE: begin
            if (pend != 8'h00) begin
               state_nxt = PRESENT;
`ifdef LAB5_EVENT_ENCODER_ROUND_ROBIN_EN
               code_nxt  = pick(pend, ptr);
`else
               code_nxt  = pick(pend, 3'd0);
`endif
            end
         end
         PRESENT: begin
            if (ack) begin
`ifdef LAB5_EVENT_ENCODER_ROUND_ROBIN_EN
               ptr_nxt = code;
`endif
               if (pend_nxt != 8'h00) begin
                  // next code uses the acknowledged code as the new base
                  code_nxt = pick(pend_nxt, code);
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending-event count straight from the registered pending bits.
   always_comb begin
      pend_cnt = 4'd0;
      for (int i = 0; i < 8; i++) pend_cnt = pend_cnt + {3'd0, pend[i]};
   end

   // State registers; reset wins over everything, including a live handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         code   <= 3'd0;
         pend   <= 8'h00;
         z_prev <= 8'h00;
         ovf    <= 1'b0;
      end else begin
         state  <= state_nxt;
         code   <= code_nxt;
         pend   <= pend_nxt;
         z_prev <= z_vec;
         ovf    <= ovf | ovf_set;
      end
   end

`ifdef LAB5_EVENT_ENCODER_ROUND_ROBIN_EN
   // Round-robin pointer follows the last acknowledged code.
   always_ff @(posedge clk) begin
      if (rst) ptr <= 3'd0;
      else     ptr <= ptr_nxt;
   end
`endif

endmodule

// File: tb/tb_lab5_event_encoder.sv
// Bench for lab5_event_encoder: directed scenarios plus random traffic. A
// transaction-level model (pending set, presented code) predicts outputs per
// cycle into a queue; a monitor on the falling edge pops and compares.
module tb_lab5_event_encoder;

   logic       clk = 1'b0;
   logic       rst, ready;
   logic [7:0] z;
   logic       a0, a1, a2, valid, ovf;
   logic [3:0] pend_cnt;

   typedef struct {
      bit valid;
      int code;
      int cnt;
      bit ovf;
   } exp_t;

   exp_t exp_q[$];
   int   nvec = 0;
   int   nerr = 0;

   // model state
   bit   m_pend[8];
   bit   m_prev[8];
   bit   m_valid;
   int   m_code;
   bit   m_ovf;
   int   m_ptr;

   lab5_event_encoder dut (
      .clk(clk), .rst(rst),
      .z0(z[0]), .z1(z[1]), .z2(z[2]), .z3(z[3]),
      .z4(z[4]), .z5(z[5]), .z6(z[6]), .z7(z[7]),
      .ready(ready),
      .a0(a0), .a1(a1), .a2(a2),
      .valid(valid), .pend_cnt(pend_cnt), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic int dut_code();
      return {29'd0, a2, a1, a0};
   endfunction

   task automatic check(input string name, input int act, input int req);
      nvec++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // choose from a set of pending lines
   function automatic int choose(input bit p[8], input int base);
      int sel;
      sel = -1;
`ifdef LAB5_EVENT_ENCODER_ROUND_ROBIN_EN
      for (int i = 1; i <= 8; i++) begin
         if (sel < 0 && p[(base - i + 16) % 8]) sel = (base - i + 16) % 8;
      end
`else
      for (int k = 7; k >= 0; k--) begin
         if (sel < 0 && p[k]) sel = k;
      end
`endif
      return sel;
   endfunction

   function automatic int count(input bit p[8]);
      int c = 0;
      for (int k = 0; k < 8; k++) c += p[k];
      return c;
   endfunction

   // Model of one clock edge with the inputs present at that edge.
   task automatic model_step(input logic [7:0] zi, input bit r, input bit rs);
      bit ev[8];
      bit after[8];
      bit old_any;
      bit acked;
      exp_t e;
      if (rs) begin
         for (int k = 0; k < 8; k++) begin m_pend[k] = 0; m_prev[k] = 0; end
         m_valid = 0; m_code = 0; m_ovf = 0; m_ptr = 0;
      end else begin
         old_any = count(m_pend) != 0;
         acked   = m_valid && r;
         for (int k = 0; k < 8; k++) begin
            ev[k] = zi[k] && !m_prev[k];
            if (ev[k] && m_pend[k] && !(acked && m_code == k)) m_ovf = 1;
         end
         if (acked) begin
            m_pend[m_code] = 0;
            m_ptr = m_code;
         end
         for (int k = 0; k < 8; k++) after[k] = m_pend[k] | ev[k];
         if (m_valid) begin
            if (acked) begin
               if (count(after) != 0) m_code = choose(after, m_ptr);
               else m_valid = 0;
            end
         end else if (old_any) begin
            m_valid = 1;
            m_code  = choose(m_pend, m_ptr);
         end
         for (int k = 0; k < 8; k++) begin m_pend[k] = after[k]; m_prev[k] = zi[k]; end
      end
      e.valid = m_valid; e.code = m_code; e.cnt = count(m_pend); e.ovf = m_ovf;
      exp_q.push_back(e);
   endtask

   // One cycle: drive, clock, predict.
   task automatic cyc(input logic [7:0] zi, input bit r, input bit rs = 1'b0);
      z = zi; ready = r; rst = rs;
      @(posedge clk);
      model_step(zi, r, rs);
      #1;
   endtask

   // Monitor: compare every cycle's presented outputs with the prediction.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("valid", int'(valid), int'(e.valid));
         check("code", dut_code(), e.code);
         check("pend_cnt", int'(pend_cnt), e.cnt);
         check("ovf", int'(ovf), int'(e.ovf));
      end
   end

   initial begin
      z = 8'h00; ready = 1'b0; rst = 1'b1;
      cyc(8'h00, 1'b1, 1'b1);
      cyc(8'h00, 1'b1, 1'b1);
      check("reset_valid", int'(valid), 0);
      check("reset_code", dut_code(), 0);
      check("reset_cnt", int'(pend_cnt), 0);

      // single z3 event held high, consumer always ready
      cyc(8'h08, 1'b1);
      check("z3_cnt", int'(pend_cnt), 1);
      check("z3_valid_wait", int'(valid), 0);
      cyc(8'h08, 1'b1);
      check("z3_valid", int'(valid), 1);
      check("z3_code", dut_code(), 3);
      for (int i = 0; i < 4; i++) cyc(8'h08, 1'b1);
      check("z3_done_valid", int'(valid), 0);
      check("z3_done_cnt", int'(pend_cnt), 0);
      cyc(8'h00, 1'b1);

      // three simultaneous events, stalled consumer, then drain
      cyc(8'h62, 1'b0);
      check("three_cnt", int'(pend_cnt), 3);
      cyc(8'h62, 1'b0);
      cyc(8'h62, 1'b0);
      for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1);

      // lost event on z2 sets sticky ovf
      cyc(8'h04, 1'b0); cyc(8'h00, 1'b0); cyc(8'h04, 1'b0); cyc(8'h00, 1'b0);
      check("ovf_set", int'(ovf), 1);
      for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1);
      check("ovf_sticky", int'(ovf), 1);
      cyc(8'h00, 1'b0, 1'b1);
      check("ovf_cleared", int'(ovf), 0);

      // z4 re-edges on the exact acknowledge of code 4
      cyc(8'h10, 1'b0); cyc(8'h00, 1'b0); cyc(8'h00, 1'b0);
      cyc(8'h10, 1'b1);
      check("reack_valid", int'(valid), 1);
      check("reack_code", dut_code(), 4);
      check("reack_ovf", int'(ovf), 0);
      for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1);

      // every line edges at once, then z7/z0 re-edge
      cyc(8'hff, 1'b1);
      check("all_cnt", int'(pend_cnt), 8);
      for (int i = 0; i < 10; i++) cyc(8'hff, 1'b1);
      cyc(8'h00, 1'b1);
      cyc(8'h81, 1'b1);
      for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1);

      // reset in the middle of a handshake with four pending
      cyc(8'h0f, 1'b0); cyc(8'h0f, 1'b0); cyc(8'h0f, 1'b1);
      cyc(8'h0f, 1'b1, 1'b1);
      check("midrst_valid", int'(valid), 0);
      check("midrst_cnt", int'(pend_cnt), 0);
      check("midrst_code", dut_code(), 0);
      for (int i = 0; i < 8; i++) cyc(8'h0f, 1'b1);
      cyc(8'h00, 1'b1);

      // random traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] zr;
         zr = 8'($urandom) & 8'($urandom) & (i[6] ? 8'hff : 8'($urandom));
         cyc(zr, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end

      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/lab5_event_encoder.md
LAB5_EVENT_ENCODER -- requirements
Module: lab5_event_encoder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 z0..z7  input  1 each  event request lines; line k carries index k.
REQ-005 a0, a1, a2  output  1 each  encoded index of presented event; a2 MSB, a0 LSB.
REQ-006 valid  output  1  the code on a2..a0 is a pending event.
REQ-007 ready  input  1  consumer accepts the presented code.
REQ-008 pend_cnt  output  4  number of pending events, range 0..8.
REQ-009 ovf  output  1  sticky flag: an event was lost.
REQ-010 All ports SHALL use the single clock clk with reset rst, synchronous and active-high.

Function
REQ-011 Each cycle SHALL register z7..z0 into a previous-sample register; an event on line k SHALL be a rising edge: current z_k=1, previous sample=0.
REQ-012 An event on line k SHALL set pending bit k at the same clock edge that detects it.
REQ-013 A level held high SHALL produce exactly one event.
REQ-014 FSM states SHALL be IDLE (valid=0) and PRESENT (valid=1).
REQ-015 IDLE -> PRESENT when the pending register is nonzero; code = selected index (REQ-021/REQ-022).
REQ-016 Latency: edge detected at clock edge N -> valid=1 with that code after clock edge N+1, when idle and no higher-priority pending.
REQ-017 In PRESENT, a2..a0 SHALL hold stable until valid&ready.
REQ-018 On valid&ready the presented pending bit SHALL clear. If other bits remain pending, or new events arrive that cycle, the FSM SHALL stay in PRESENT with the next selected code after the same edge (back-to-back, no bubble). Otherwise it SHALL return to IDLE.
REQ-019 ready while valid=0 SHALL have no effect.
REQ-020 If an event on line k coincides with the acknowledge of code k, bit k SHALL remain set and ovf SHALL NOT assert.
REQ-021 Fixed priority: highest pending index wins (z7 highest).
REQ-022 Selection SHALL occur only on entry to PRESENT or on acknowledge. A new higher-priority event SHALL NOT replace a code already presented.
REQ-023 An event on line k with bit k already set and not cleared that cycle SHALL set ovf=1 until reset. Bit k SHALL stay set (one event lost).
REQ-024 pend_cnt SHALL equal the popcount of the registered pending bits.
REQ-025 All 8 lines edging in one cycle SHALL set all bits; pend_cnt=8 on the next cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL take effect at that edge, including mid-handshake: pending=0, previous-sample=0, FSM=IDLE, valid=0, a2..a0=000, pend_cnt=0, ovf=0, round-robin pointer=0.
REQ-027 A line already high at reset release SHALL produce one event on the first post-reset clock edge.
REQ-028 While rst=1, ready and z inputs SHALL be ignored.

Configuration
REQ-029 Macro LAB5_EVENT_ENCODER_ROUND_ROBIN_EN SHALL control the priority scheme.
REQ-030 With the macro defined, a 3-bit pointer SHALL be loaded with the code on each valid&ready. Selection SHALL search descending from pointer-1, wrapping 0 -> 7, pointer last. After reset the pointer is 0, so the first search starts at 7.
REQ-031 Without the macro, fixed priority per REQ-021 SHALL apply and the pointer logic SHALL not exist. All other behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset, z3 0->1 held high, ready=1 -> one cycle valid=1 with a2..a0=011, one edge after detection; then valid=0, pend_cnt=0.
REQ-033 z1, z5, z6 edge in the same cycle, ready=0 for 3 cycles then 1 -> pend_cnt=3; codes presented back-to-back 110, 101, 001 (fixed build).
REQ-034 z2 pulse, ready=0, z2 pulses again before acknowledge -> ovf=1 sticky; a single 010 delivered; ovf cleared only by rst.
REQ-035 z4 edge on the exact cycle code 100 is acknowledged -> no ovf; 100 presented again on the next cycle.
REQ-036 All lines edge with ready=1, round-robin build -> codes 7,6,...,0; then z7, z0 re-edge with last code 0 -> order 7, 0. Fixed build also gives 7, 0.
REQ-037 rst asserted while valid=1 with 4 pending -> after the edge valid=0, pend_cnt=0, a2..a0=000; lines still high produce new events after release.
